// File: rtl/reg_stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_stack_ctrl_pkg
// Description : Shared sizing defaults and register-number helpers for the
//               register stack request sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_stack_ctrl_pkg;

  localparam int NIB_SIZE_DEF       = 4;
  localparam int WORD_SIZE_DEF      = 16;
  localparam int REG_STACK_SIZE_DEF = 16;

  // True when the register number maps onto real storage that may be strobed.
  function automatic logic reg_live(input logic [31:0] num,
                                    input int unsigned size,
                                    input logic        zero_reg);
    return (num < size) && !(zero_reg && (num == 32'd0));
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_stack_ctrl
// Description : Valid/ready request sequencer driving the strobe-clocked
//               register stack port. Optional macro REG_STACK_CTRL_ZERO_REG_EN
//               hard-wires register 0 to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_stack_ctrl
  import reg_stack_ctrl_pkg::*;
#(
  parameter int NIB_SIZE       = NIB_SIZE_DEF,
  parameter int WORD_SIZE      = WORD_SIZE_DEF,
  parameter int REG_STACK_SIZE = REG_STACK_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [NIB_SIZE-1:0]  wr_num,
  input  logic [WORD_SIZE-1:0] wr_val,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [NIB_SIZE-1:0]  rd_num1,
  input  logic [NIB_SIZE-1:0]  rd_num2,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WORD_SIZE-1:0] res_out1,
  output logic [WORD_SIZE-1:0] res_out2,
  output logic [NIB_SIZE-1:0]  rs_num1,
  output logic [NIB_SIZE-1:0]  rs_num2,
  output logic [NIB_SIZE-1:0]  rs_setnum,
  output logic [WORD_SIZE-1:0] rs_setval,
  output logic                 rs_get_clk,
  output logic                 rs_set_clk,
  input  logic [WORD_SIZE-1:0] rs_out1,
  input  logic [WORD_SIZE-1:0] rs_out2
);

`ifdef REG_STACK_CTRL_ZERO_REG_EN
  localparam logic c_zero_reg_en = 1'b1;
`else
  localparam logic c_zero_reg_en = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_SETUP = 3'd1,
    S_W_PULSE = 3'd2,
    S_R_SETUP = 3'd3,
    S_R_PULSE = 3'd4,
    S_R_CAPT  = 3'd5,
    S_R_DONE  = 3'd6
  } state_t;

  state_t r_state;
  logic   r_wr_live;
  logic   r_rd_live1;
  logic   r_rd_live2;

  logic w_wr_live;
  logic w_rd_live1;
  logic w_rd_live2;

  assign w_wr_live  = reg_live(32'(wr_num),  REG_STACK_SIZE, c_zero_reg_en);
  assign w_rd_live1 = reg_live(32'(rd_num1), REG_STACK_SIZE, c_zero_reg_en);
  assign w_rd_live2 = reg_live(32'(rd_num2), REG_STACK_SIZE, c_zero_reg_en);

  assign wr_ready = (r_state == S_IDLE) && !reset;
  assign rd_ready = (r_state == S_IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_live  <= 1'b0;
      r_rd_live1 <= 1'b0;
      r_rd_live2 <= 1'b0;
      res_valid  <= 1'b0;
      res_out1   <= '0;
      res_out2   <= '0;
      rs_num1    <= '0;
      rs_num2    <= '0;
      rs_setnum  <= '0;
      rs_setval  <= '0;
      rs_get_clk <= 1'b0;
      rs_set_clk <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Writes are older in program order, so they win a simultaneous request.
          if (wr_valid) begin
            rs_setnum <= wr_num;
            rs_setval <= wr_val;
            r_wr_live <= w_wr_live;
            r_state   <= S_W_SETUP;
          end else if (rd_valid) begin
            rs_num1    <= rd_num1;
            rs_num2    <= rd_num2;
            r_rd_live1 <= w_rd_live1;
            r_rd_live2 <= w_rd_live2;
            r_state    <= S_R_SETUP;
          end
        end
        S_W_SETUP: begin
          rs_set_clk <= r_wr_live;
          r_state    <= S_W_PULSE;
        end
        S_W_PULSE: begin
          rs_set_clk <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_R_SETUP: begin
          rs_get_clk <= 1'b1;
          r_state    <= S_R_PULSE;
        end
        S_R_PULSE: begin
          rs_get_clk <= 1'b0;
          r_state    <= S_R_CAPT;
        end
        S_R_CAPT: begin
          res_out1  <= r_rd_live1 ? rs_out1 : '0;
          res_out2  <= r_rd_live2 ? rs_out2 : '0;
          res_valid <= 1'b1;
          r_state   <= S_R_DONE;
        end
        S_R_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          rs_get_clk <= 1'b0;
          rs_set_clk <= 1'b0;
          res_valid  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/reg_stack_ctrl.md
# reg_stack_ctrl

Request-side sequencer for the register stack. Accepts register read and write requests from the execution unit over valid/ready handshakes and drives the stack's strobe-clocked port: register numbers, write value, and one-cycle `get_clk`/`set_clk` pulses. It captures the stack's two read outputs and returns them as one result. It sits between the core datapath and the register stack and is the only agent that toggles the stack strobes.

## Interface
- NIB_SIZE, 4, register-number width
- WORD_SIZE, 16, data word width
- REG_STACK_SIZE, 16, number of implemented registers (≤ 2^NIB_SIZE)

- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write request present
- wr_ready  out  1  controller can accept a write
- wr_num  in  NIB_SIZE  register to write
- wr_val  in  WORD_SIZE  value to write
- rd_valid  in  1  read request present
- rd_ready  out  1  controller can accept a read
- rd_num1, rd_num2  in  NIB_SIZE  registers to read
- res_valid  out  1  read result available
- res_ready  in  1  consumer takes result
- res_out1, res_out2  out  WORD_SIZE  read data for rd_num1 and rd_num2
- rs_num1, rs_num2, rs_setnum  out  NIB_SIZE  to stack
- rs_setval  out  WORD_SIZE  to stack
- rs_get_clk, rs_set_clk  out  1  stack strobes, registered
- rs_out1, rs_out2  in  WORD_SIZE  from stack

## Operation
- FSM states: IDLE, W_SETUP, W_PULSE, R_SETUP, R_PULSE, R_CAPT, R_DONE.
- wr_ready = rd_ready = (state == IDLE) && !reset.
- If wr_valid and rd_valid are both high in IDLE, the write is accepted and the read waits. Writes are older in program order.
- Write path:
  - Accept: latch rs_setnum/rs_setval and go to W_SETUP.
  - W_SETUP → W_PULSE; rs_set_clk=1 for that one cycle.
  - W_PULSE → IDLE; rs_set_clk=0.
- Read path:
  - Accept: latch rs_num1/rs_num2 and go to R_SETUP.
  - R_SETUP → R_PULSE; rs_get_clk=1.
  - R_PULSE → R_CAPT; rs_get_clk=0.
  - At the end of R_CAPT, sample rs_out1/rs_out2 into res_out1/res_out2 and go to R_DONE.
  - In R_DONE, res_valid=1. On res_ready, go to IDLE and drop res_valid. res_out* hold their value until the next capture.
- rs_num*, rs_setnum and rs_setval stay stable from the setup cycle through the pulse cycle and the cycle after it.
- Register number ≥ REG_STACK_SIZE:
  - Write: accepted with the same timing, but rs_set_clk is never pulsed.
  - Read: that operand returns 0.
- Reset values: state IDLE; every output 0, including rs_get_clk, rs_set_clk, res_valid and res_out*.
- Reset mid-operation:
  - Both strobes fall at the reset edge.
  - A write whose pulse has already risen is committed in the stack.
  - A write in W_SETUP is dropped.
  - A read in progress is discarded with no res_valid.

## Timing
- Write: accept at edge E0; rs_set_clk high E1→E2; wr_ready high again after E2. Throughput is one write per 3 cycles.
- Read: accept at E0; rs_get_clk high E1→E2; capture at E3; res_valid high from E3. Latency is 3 cycles, plus time spent waiting in R_DONE.
- Each strobe is high for exactly one clk period. There is at least one setup cycle before each strobe rise.
- rs_get_clk and rs_set_clk are never high in the same cycle.
- A read issued the cycle after a write completes sees the written value. This needs no forwarding.

## Configuration
- Macro: REG_STACK_CTRL_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-wired to zero. A read operand of 0 returns 0 regardless of rs_out*.
  - A write to 0 is accepted with normal timing, but rs_set_clk is not pulsed.
- Undefined: register 0 is an ordinary register.

## Structure
- NIB_SIZE, WORD_SIZE and REG_STACK_SIZE defaults come from the shared parameters include.
- FSM state encodings are local to the module.
- No sub-module. The reg_stack instance lives in the parent and in the bench, never inside this block.

## Test plan
- Write 0x1234 to reg 5, then read (5,5) → one rs_set_clk pulse with rs_setnum=5; res_out1=res_out2=0x1234 valid 3 cycles after read accept.
- wr_valid and rd_valid high together (write reg 3=0x00AA, read (3,2)) → write strobe first; read returns (0x00AA, 0).
- Hold res_ready=0 for 5 cycles → res_valid and data stay stable, rd_ready stays 0; accept on cycle 6, then back to IDLE.
- Reset asserted in W_PULSE, then in R_PULSE → strobes 0 next cycle; all outputs 0; the W_PULSE write is visible in the stack; no res_valid.
- Read reg 15 with REG_STACK_SIZE=8 → returns 0; write to reg 15 → no rs_set_clk pulse.
- With REG_STACK_CTRL_ZERO_REG_EN, write 0xFFFF to reg 0, then read (0,1) → no set pulse; res_out1=0.
